// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs a single-outstanding req/ack fetch to imem and
// buffers up to two instructions for decode. Define IF_ALIGN_CHECK_EN to flag misaligned redirects.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLOCK,
  input  logic        RESET_N,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  input  logic        Stall,
  input  logic        Flush,
  input  logic [31:0] redirect_PC,
  output logic [31:0] inst_out,
  output logic [31:0] PC_add4_out,
  output logic        inst_valid,
  output logic        addr_err
);

  typedef enum logic [1:0] {StIdle, StBusy, StDrain} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] inst_q [2];
  logic [31:0] inst_d [2];
  logic [31:0] pca4_q [2];
  logic [31:0] pca4_d [2];
  logic [1:0]  count_q, count_d;

  logic        pop;
  logic        push;
  logic        room;
  logic [1:0]  count_after;
  logic [1:0]  cnt_tmp;
  logic [31:0] next_addr;
  logic [31:0] redirect_eff;

  assign next_addr   = req_addr_q + 32'd4;
  assign pop         = (count_q != 2'd0) && !Stall && !Flush;
  assign push        = (state_q == StBusy) && imem_ack && !Flush;
  assign count_after = count_q - {1'b0, pop} + {1'b0, push};
  assign room        = (count_after != 2'd2);

`ifdef IF_ALIGN_CHECK_EN
  logic addr_err_q, addr_err_d;

  assign redirect_eff = {redirect_PC[31:2], 2'b00};

  always_comb begin
    addr_err_d = addr_err_q;
    if (Flush && (redirect_PC[1:0] != 2'b00)) begin
      addr_err_d = 1'b1;
    end
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      addr_err_q <= 1'b0;
    end else begin
      addr_err_q <= addr_err_d;
    end
  end

  assign addr_err = addr_err_q;
`else
  assign redirect_eff = redirect_PC;
  assign addr_err     = 1'b0;
`endif

  // State register
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (!Flush && (count_q != 2'd2)) state_d = StBusy;
      end
      StBusy: begin
        // The outstanding request must still complete after a flush, so drain it.
        if (Flush) begin
          state_d = imem_ack ? StIdle : StDrain;
        end else if (imem_ack && !room) begin
          state_d = StIdle;
        end
      end
      StDrain: begin
        if (imem_ack) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state: PC, request address and the 2-entry FIFO (entry 0 is the head)
  always_comb begin
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    inst_d     = inst_q;
    pca4_d     = pca4_q;
    cnt_tmp    = count_q;

    if (pop) begin
      inst_d[0] = inst_q[1];
      pca4_d[0] = pca4_q[1];
      cnt_tmp   = count_q - 2'd1;
    end
    if (push) begin
      inst_d[cnt_tmp[0]] = imem_data;
      pca4_d[cnt_tmp[0]] = next_addr;
      cnt_tmp            = cnt_tmp + 2'd1;
      pc_d               = next_addr;
      if (room) req_addr_d = next_addr;
    end
    if ((state_q == StIdle) && !Flush && (count_q != 2'd2)) begin
      req_addr_d = pc_q;
    end

    count_d = cnt_tmp;
    if (Flush) begin
      pc_d    = redirect_eff;
      count_d = 2'd0;
    end
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      count_q    <= 2'd0;
      inst_q[0]  <= 32'd0;
      inst_q[1]  <= 32'd0;
      pca4_q[0]  <= 32'd0;
      pca4_q[1]  <= 32'd0;
    end else begin
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      count_q    <= count_d;
      inst_q     <= inst_d;
      pca4_q     <= pca4_d;
    end
  end

  // Outputs, decoded only from registered state
  always_comb begin
    imem_req    = (state_q != StIdle);
    imem_addr   = req_addr_q;
    inst_valid  = (count_q != 2'd0);
    inst_out    = 32'd0;
    PC_add4_out = pc_q;
    if (count_q != 2'd0) begin
      inst_out    = inst_q[0];
      PC_add4_out = pca4_q[0];
    end
  end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage that produces the instruction/PC+4 pair consumed by the IF/ID pipeline register and decode stage, and honours the Stall, Flush and redirect-target signals that decode drives back. It owns the program counter. It runs a single-outstanding request/acknowledge handshake to instruction memory, and buffers up to two fetched instructions so a decode stall does not back-pressure memory mid-transaction.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- CLOCK  in  1  rising-edge clock
- RESET_N  in  1  asynchronous, active-low reset
- imem_req  out  1  request to instruction memory; held high until acknowledged
- imem_addr  out  32  word address of the outstanding request; stable while imem_req=1
- imem_ack  in  1  memory has returned imem_data for the outstanding request (sampled on CLOCK rise while imem_req=1)
- imem_data  in  32  instruction word, valid when imem_ack=1
- Stall  in  1  decode cannot accept this cycle; hold output
- Flush  in  1  redirect: discard all fetched/in-flight instructions and restart at redirect_PC
- redirect_PC  in  32  branch/jump target, valid when Flush=1
- inst_out  out  32  instruction to IF/ID; 32'b0 (NOP) when inst_valid=0
- PC_add4_out  out  32  address of inst_out plus 4; equals current fetch PC when inst_valid=0
- inst_valid  out  1  inst_out/PC_add4_out carry a real instruction
- addr_err  out  1  misaligned redirect seen (only with IF_ALIGN_CHECK_EN)

## Operation
- Registers: PC (next address to fetch), req_addr, 2-entry FIFO of {inst, addr+4}, 2-bit count, FSM state.
- FSM states: IDLE (no request), BUSY (request outstanding, response kept), DRAIN (request outstanding, response discarded).
- IDLE -> BUSY when count<2 and no Flush: req_addr<=PC, imem_req<=1.
- BUSY, imem_ack=1: push {imem_data, req_addr+4}, PC<=req_addr+4; if room remains after this cycle's push/pop, stay BUSY with req_addr<=req_addr+4 (back-to-back), else -> IDLE.
- Space check: room = (count - pop + push) < 2.
- Pop: when inst_valid=1 and Stall=0 and Flush=0, head leaves at the clock edge.
- Flush (priority over Stall and ack): FIFO cleared, PC<=redirect_PC.
  - IDLE or BUSY with ack same cycle -> IDLE (ack data dropped).
  - BUSY without ack -> DRAIN; imem_req stays high, imem_addr unchanged.
- DRAIN: on ack, drop data -> IDLE. Flush in DRAIN: PC<=newer redirect_PC, stay DRAIN.
- imem_req is never deasserted before ack; imem_addr never changes while unacknowledged.
- Empty FIFO: inst_out=0, inst_valid=0, PC_add4_out=PC.
- Address arithmetic modulo 2^32; PC 32'hFFFF_FFFC wraps to 0.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, inst_out=0, PC_add4_out=RESET_PC, inst_valid=0, addr_err=0, state IDLE, count 0. Reset mid-transaction abandons the request immediately.
- First imem_req rises the first edge after RESET_N deasserts.
- Zero-wait memory (ack in first req cycle): one instruction per cycle; first inst_valid two edges after reset release.
- Fetch-to-output latency: entry visible on inst_out the cycle after the ack edge.
- Flush: inst_valid=0 the cycle after the Flush edge; first redirected request the cycle after IDLE is reached.
- All outputs flop-driven; no combinational path from inputs to outputs.

## Configuration
- IF_ALIGN_CHECK_EN defined: redirect_PC[1:0]!=0 on Flush sets addr_err (sticky until reset), and PC loads {redirect_PC[31:2],2'b00}.
- Undefined: addr_err tied 0; redirect_PC loaded unmodified.

## Test plan
- Reset, RESET_PC=0, memory acks each req same cycle -> imem_addr 0,4,8,...; inst_out follows memory, PC_add4_out 4,8,12; one valid per cycle.
- Stall held 3 cycles with zero-wait memory -> count reaches 2, imem_req drops, inst_out/PC_add4_out held; after release no instruction lost or duplicated.
- Memory ack delayed 4 cycles; Flush with redirect_PC=32'h40 in cycle 2 -> imem_addr held until ack, that data dropped (DRAIN), next request addr 32'h40, first valid PC_add4_out=32'h44.
- Flush and imem_ack same edge -> acked word never appears; next request 32'h40.
- RESET_PC=32'hFFFF_FFFC -> second request addr 0, PC_add4_out 0 then 4.
- With IF_ALIGN_CHECK_EN, Flush redirect_PC=32'h42 -> addr_err=1, next imem_addr 32'h40; without macro, next imem_addr 32'h42, addr_err=0.
